// File: rtl/lcd_timing_sequencer.sv
// lcd_timing_sequencer: 480x272 LCD raster timing with warm-up/run/drain sequencing of the pixel stage
module lcd_timing_sequencer #(
  parameter int H_ACTIVE      = 480,
  parameter int H_FRONT       = 2,
  parameter int H_SYNC        = 41,
  parameter int H_BACK        = 2,
  parameter int V_ACTIVE      = 272,
  parameter int V_FRONT       = 2,
  parameter int V_SYNC        = 10,
  parameter int V_BACK        = 2,
  parameter int WARMUP_FRAMES = 2
) (
  input  logic       clk9MHz,
  input  logic       rst_n,
  input  logic       enable,
  output logic [9:0] vgaCount,
  output logic [8:0] lineCount,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       dataEnable,
  output logic       start,
  output logic       frameStart,
  output logic [1:0] state
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_VIS  = 9'(V_ACTIVE);
  localparam logic [8:0] VS_BEG = 9'(V_ACTIVE + V_FRONT);
  localparam logic [8:0] VS_END = 9'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [3:0] WU_LAST = 4'(WARMUP_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, DRAIN} st_t;

  st_t        st, ns;
  logic [9:0] nv;
  logic [8:0] nl;
  logic [3:0] fc;
  logic       h_end, fe, clr, act;

  assign state = st;

  // next state and next counter values; outputs are decoded from these so they stay coherent
  always_comb begin
    h_end = vgaCount == H_LAST;
    fe    = h_end && lineCount == V_LAST;
    ns    = st == IDLE   ? (enable ? WARMUP : IDLE)
          : st == WARMUP ? (!enable ? IDLE : (fe && fc == WU_LAST) ? RUN : WARMUP)
          : st == RUN    ? (enable ? RUN : DRAIN)
          : (enable ? RUN : fe ? IDLE : DRAIN);
    clr   = st == IDLE || ns == IDLE;
    act   = ns == RUN || ns == DRAIN;
    nv    = (clr || h_end) ? '0 : vgaCount + 10'd1;
    nl    = (clr || fe) ? '0 : h_end ? lineCount + 9'd1 : lineCount;
  end

  // registered state, counters, decodes and warm-up frame count
  always_ff @(posedge clk9MHz or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      vgaCount   <= '0;
      lineCount  <= '0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      dataEnable <= 1'b0;
      start      <= 1'b0;
      frameStart <= 1'b0;
      fc         <= '0;
    end else begin
      st         <= ns;
      vgaCount   <= nv;
      lineCount  <= nl;
      hsync_n    <= !(nv >= HS_BEG && nv < HS_END);
      vsync_n    <= !(nl >= VS_BEG && nl < VS_END);
      dataEnable <= act && nv < H_VIS && nl < V_VIS;
      start      <= act;
      frameStart <= ns != IDLE && nv == '0 && nl == '0;
      fc         <= ns != WARMUP ? '0 : (st == WARMUP && fe) ? fc + 4'd1 : fc;
    end
  end
endmodule

// File: tb/tb_lcd_timing_sequencer.sv
// tb_lcd_timing_sequencer: cycle-tagged scoreboard of hand-computed outputs for a shrunk and a default-size raster
module tb_lcd_timing_sequencer;
  logic clk9MHz = 0, rst_n = 0, enable = 0, enable_d = 0;
  logic [9:0] vga_a, vga_b;
  logic [8:0] line_a, line_b;
  logic hs_a, vs_a, de_a, s_a, fs_a, hs_b, vs_b, de_b, s_b, fs_b;
  logic [1:0] st_a, st_b;
  int cyc = 0, checks = 0, errors = 0;

  typedef struct {
    int c; bit d; logic [1:0] st; int v; int l;
    logic s; logic de; logic fs; logic hs; logic vs; string n;
  } exp_t;
  exp_t sb[$];

  // small raster: H_TOTAL=15 (vis 0..7, hsync 10..12), V_TOTAL=8 (vis 0..3, vsync 5..6), frame=120 clocks
  lcd_timing_sequencer #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .WARMUP_FRAMES(2)
  ) dut (
    .clk9MHz(clk9MHz), .rst_n(rst_n), .enable(enable),
    .vgaCount(vga_a), .lineCount(line_a), .hsync_n(hs_a), .vsync_n(vs_a),
    .dataEnable(de_a), .start(s_a), .frameStart(fs_a), .state(st_a)
  );

  lcd_timing_sequencer dut_d (
    .clk9MHz(clk9MHz), .rst_n(rst_n), .enable(enable_d),
    .vgaCount(vga_b), .lineCount(line_b), .hsync_n(hs_b), .vsync_n(vs_b),
    .dataEnable(de_b), .start(s_b), .frameStart(fs_b), .state(st_b)
  );

  always #5 clk9MHz = ~clk9MHz;

  always @(posedge clk9MHz) cyc <= cyc + 1;

  function automatic void ex(int c, logic [1:0] st, int v, int l, logic s, logic de,
                             logic fs, logic hs, logic vs, string n, bit d = 0);
    exp_t e;
    e.c = c; e.d = d; e.st = st; e.v = v; e.l = l;
    e.s = s; e.de = de; e.fs = fs; e.hs = hs; e.vs = vs; e.n = n;
    sb.push_back(e);
  endfunction

  task automatic go(int n);
    while (cyc < n) @(negedge clk9MHz);
  endtask

  // monitor: every clock the DUT presents a full output set; compare any expectation tagged for this cycle
  always @(negedge clk9MHz) begin
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].c == cyc) begin
        logic [25:0] got, want;
        got = sb[i].d ? {st_b, vga_b, line_b, s_b, de_b, fs_b, hs_b, vs_b}
                      : {st_a, vga_a, line_a, s_a, de_a, fs_a, hs_a, vs_a};
        want = {sb[i].st, 10'(sb[i].v), 9'(sb[i].l), sb[i].s, sb[i].de, sb[i].fs, sb[i].hs, sb[i].vs};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s cyc=%0d got st=%0d v=%0d l=%0d s/de/fs/hs/vs=%b want st=%0d v=%0d l=%0d s/de/fs/hs/vs=%b",
                   sb[i].n, cyc, got[25:24], got[23:14], got[13:5], got[4:0],
                   want[25:24], want[23:14], want[13:5], want[4:0]);
        end
        sb.delete(i);
      end
  end

  initial begin
    ex(2, 0, 0, 0, 0, 0, 0, 1, 1, "rst");
    ex(5, 0, 0, 0, 0, 0, 0, 1, 1, "idle");
    ex(6, 1, 0, 0, 0, 0, 1, 1, 1, "wu_fs");
    ex(7, 1, 1, 0, 0, 0, 0, 1, 1, "wu_cnt");
    ex(15, 1, 9, 0, 0, 0, 0, 1, 1, "hs_pre");
    ex(16, 1, 10, 0, 0, 0, 0, 0, 1, "hs_beg");
    ex(18, 1, 12, 0, 0, 0, 0, 0, 1, "hs_last");
    ex(19, 1, 13, 0, 0, 0, 0, 1, 1, "hs_end");
    ex(20, 1, 14, 0, 0, 0, 0, 1, 1, "h_last");
    ex(21, 1, 0, 1, 0, 0, 0, 1, 1, "h_wrap");
    ex(80, 1, 14, 4, 0, 0, 0, 1, 1, "vs_pre");
    ex(81, 1, 0, 5, 0, 0, 0, 1, 0, "vs_beg");
    ex(110, 1, 14, 6, 0, 0, 0, 1, 0, "vs_last");
    ex(111, 1, 0, 7, 0, 0, 0, 1, 1, "vs_end");
    ex(125, 1, 14, 7, 0, 0, 0, 1, 1, "fe1");
    ex(126, 1, 0, 0, 0, 0, 1, 1, 1, "wu_f2");
    ex(245, 1, 14, 7, 0, 0, 0, 1, 1, "fe2");
    ex(246, 2, 0, 0, 1, 1, 1, 1, 1, "run_start");
    ex(253, 2, 7, 0, 1, 1, 0, 1, 1, "de_last");
    ex(254, 2, 8, 0, 1, 0, 0, 1, 1, "de_off");
    ex(291, 2, 0, 3, 1, 1, 0, 1, 1, "de_l3");
    ex(306, 2, 0, 4, 1, 0, 0, 1, 1, "de_l4");
    ex(366, 2, 0, 0, 1, 1, 1, 1, 1, "run_f2");
    ex(6, 1, 0, 0, 0, 0, 1, 1, 1, "d_fs", 1);
    ex(487, 1, 481, 0, 0, 0, 0, 1, 1, "d_hs_pre", 1);
    ex(488, 1, 482, 0, 0, 0, 0, 0, 1, "d_hs_beg", 1);
    ex(528, 1, 522, 0, 0, 0, 0, 0, 1, "d_hs_last", 1);
    ex(529, 1, 523, 0, 0, 0, 0, 1, 1, "d_hs_end", 1);
    ex(530, 1, 524, 0, 0, 0, 0, 1, 1, "d_h_last", 1);
    ex(531, 1, 0, 1, 0, 0, 0, 1, 1, "d_wrap", 1);
    ex(1056, 1, 0, 2, 0, 0, 0, 1, 1, "d_l2", 1);
    go(3); rst_n = 1;
    go(5); enable = 1; enable_d = 1;
    ex(395, 2, 14, 1, 1, 0, 0, 1, 1, "pre_drain");
    ex(396, 3, 0, 2, 1, 1, 0, 1, 1, "drain");
    ex(485, 3, 14, 7, 1, 0, 0, 1, 1, "drain_fe");
    ex(486, 0, 0, 0, 0, 0, 0, 1, 1, "drain_idle");
    ex(490, 0, 0, 0, 0, 0, 0, 1, 1, "idle_hold");
    go(395); enable = 0;
    ex(501, 1, 0, 0, 0, 0, 1, 1, 1, "wu2");
    go(500); enable = 1;
    ex(650, 1, 14, 1, 0, 0, 0, 1, 1, "wu_abort_pre");
    ex(651, 0, 0, 0, 0, 0, 0, 1, 1, "wu_abort");
    go(650); enable = 0;
    ex(661, 1, 0, 0, 0, 0, 1, 1, 1, "wu3");
    ex(781, 1, 0, 0, 0, 0, 1, 1, 1, "wu3_f2");
    ex(901, 2, 0, 0, 1, 1, 1, 1, 1, "run3");
    ex(916, 3, 0, 1, 1, 1, 0, 1, 1, "drain2");
    go(660); enable = 1;
    go(915); enable = 0;
    ex(945, 3, 14, 2, 1, 0, 0, 1, 1, "drain2_end");
    ex(946, 2, 0, 3, 1, 1, 0, 1, 1, "rerun");
    ex(1021, 2, 0, 0, 1, 1, 1, 1, 1, "rerun_f");
    go(945); enable = 1;
    ex(1140, 2, 14, 7, 1, 0, 0, 1, 1, "fe_drop_pre");
    ex(1141, 3, 0, 0, 1, 1, 1, 1, 1, "fe_drop");
    ex(1260, 3, 14, 7, 1, 0, 0, 1, 1, "fe_drain_end");
    ex(1261, 0, 0, 0, 0, 0, 0, 1, 1, "fe_idle");
    go(1140); enable = 0;
    ex(1271, 1, 0, 0, 0, 0, 1, 1, 1, "wu4");
    ex(1510, 1, 14, 7, 0, 0, 0, 1, 1, "wu4_fe");
    ex(1511, 0, 0, 0, 0, 0, 0, 1, 1, "wu4_idle");
    go(1270); enable = 1;
    go(1510); enable = 0;
    ex(1521, 1, 0, 0, 0, 0, 1, 1, 1, "wu5");
    ex(1761, 2, 0, 0, 1, 1, 1, 1, 1, "run5");
    ex(1796, 2, 5, 2, 1, 1, 0, 1, 1, "run5_mid");
    ex(1797, 0, 0, 0, 0, 0, 0, 1, 1, "async_rst");
    ex(1801, 1, 0, 0, 0, 0, 1, 1, 1, "post_rst");
    ex(2041, 2, 0, 0, 1, 1, 1, 1, 1, "post_rst_run");
    go(1520); enable = 1;
    go(1796);
    @(posedge clk9MHz);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({st_a, vga_a, line_a, s_a, de_a, fs_a, hs_a, vs_a} !== {2'd0, 10'd0, 9'd0, 5'b00011}) begin
      errors++;
      $display("FAIL async_now st=%0d v=%0d l=%0d s/de/fs/hs/vs=%b", st_a, vga_a, line_a,
               {s_a, de_a, fs_a, hs_a, vs_a});
    end
    checks++;
    if ({st_b, vga_b, line_b, s_b, de_b, fs_b, hs_b, vs_b} !== {2'd0, 10'd0, 9'd0, 5'b00011}) begin
      errors++;
      $display("FAIL d_async_now st=%0d v=%0d l=%0d s/de/fs/hs/vs=%b", st_b, vga_b, line_b,
               {s_b, de_b, fs_b, hs_b, vs_b});
    end
    go(1800); rst_n = 1;
    go(2050);
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s never compared, cyc=%0d pending", sb[i].n, sb[i].c);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
